// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: eight-op bitwise logic unit behind a two-stage valid/ready pipeline with zero flag.
// Defining LOGIC_UNIT_PARITY_EN adds a registered PARITY output (XOR-reduce of Y).
module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             ZERO
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             PARITY
`endif
);

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = ~(a | b);
      3'b011:  r = ~a;
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a & b);
      3'b110:  r = ~(a ^ b);
      3'b111:  r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic             s1_v_q, s1_v_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             s2_load_s;
  logic             s1_load_s;
  logic [WIDTH-1:0] res_s;

  // Handshake decode and next-state for both stages; data only moves on a transfer.
  always_comb begin
    s2_load_s = !s2_v_q || OUT_READY;
    IN_READY  = !s1_v_q || s2_load_s;
    s1_load_s = IN_VALID && IN_READY;
    res_s     = logic_op(s1_op_q, s1_a_q, s1_b_q);

    s1_v_d  = s1_v_q;
    s1_op_d = s1_op_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s2_v_d  = s2_v_q;
    y_d     = y_q;
    zero_d  = zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
    parity_d = parity_q;
`endif

    if (IN_READY) begin
      s1_v_d = IN_VALID;
    end else begin
      s1_v_d = s1_v_q;
    end

    if (s1_load_s) begin
      s1_op_d = OP;
      s1_a_d  = A;
      s1_b_d  = B;
    end else begin
      s1_op_d = s1_op_q;
    end

    // An empty S1 still advances into S2 as a bubble, which clears s2_v.
    if (s2_load_s) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        y_d    = res_s;
        zero_d = (res_s == {WIDTH{1'b0}});
`ifdef LOGIC_UNIT_PARITY_EN
        parity_d = parity_of(res_s);
`endif
      end else begin
        y_d = y_q;
      end
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Pipeline registers with asynchronous clear of all in-flight state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_v_q  <= 1'b0;
      s1_op_q <= 3'b000;
      s1_a_q  <= {WIDTH{1'b0}};
      s1_b_q  <= {WIDTH{1'b0}};
      s2_v_q  <= 1'b0;
      y_q     <= {WIDTH{1'b0}};
      zero_q  <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      s1_v_q  <= s1_v_d;
      s1_op_q <= s1_op_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s2_v_q  <= s2_v_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
`ifdef LOGIC_UNIT_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign OUT_VALID = s2_v_q;
  assign Y         = y_q;
  assign ZERO      = zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
  assign PARITY    = parity_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: WIDTH=1/32/64 instances share stimulus; a queue-based model of accepted
// transactions predicts readiness, validity and results.
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  op_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        out_ready;

  logic [2:0]  ir_w, ov_w, zs_w, pr_w;
  logic [0:0]  y1;
  logic [31:0] y32;
  logic [63:0] y64;
  logic [63:0] ys [3];

  assign ys[0] = {63'd0, y1};
  assign ys[1] = {32'd0, y32};
  assign ys[2] = y64;

  logic_unit_pipe #(.WIDTH(1)) u_w1 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(ir_w[0]), .OP(op_i),
    .A(a_i[0:0]), .B(b_i[0:0]), .OUT_VALID(ov_w[0]), .OUT_READY(out_ready),
    .Y(y1), .ZERO(zs_w[0])
`ifdef LOGIC_UNIT_PARITY_EN
    , .PARITY(pr_w[0])
`endif
  );

  logic_unit_pipe #(.WIDTH(32)) u_w32 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(ir_w[1]), .OP(op_i),
    .A(a_i[31:0]), .B(b_i[31:0]), .OUT_VALID(ov_w[1]), .OUT_READY(out_ready),
    .Y(y32), .ZERO(zs_w[1])
`ifdef LOGIC_UNIT_PARITY_EN
    , .PARITY(pr_w[1])
`endif
  );

  logic_unit_pipe #(.WIDTH(64)) u_w64 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(ir_w[2]), .OP(op_i),
    .A(a_i), .B(b_i), .OUT_VALID(ov_w[2]), .OUT_READY(out_ready),
    .Y(y64), .ZERO(zs_w[2])
`ifdef LOGIC_UNIT_PARITY_EN
    , .PARITY(pr_w[2])
`endif
  );

`ifndef LOGIC_UNIT_PARITY_EN
  assign pr_w = 3'b000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          stamp;
    bit          has_e;
    logic [63:0] e;
  } txn_t;

  txn_t q[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_err   = 0;
  bit   fire_in = 1'b0;
  int   wd [3]  = '{1, 32, 64};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Spec-level operation table applied at 64 bits, then cut to the instance width.
  function automatic logic [63:0] ref_y(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input int w);
    logic [63:0] r;
    logic [63:0] m;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~(a | b);
      3'd3:    r = ~a;
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a & b);
      3'd6:    r = ~(a ^ b);
      default: r = a;
    endcase
    m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return r & m;
  endfunction

  // One clock cycle: drive, check at the falling edge against the model, then commit transfers.
  task automatic step(input logic v, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic ordy, input bit has_e, input logic [63:0] e);
    bit          exp_ir;
    bit          exp_ov;
    bit          fire_out;
    logic [63:0] ey;
    txn_t        t;
    in_valid  = v;
    op_i      = op;
    a_i       = a;
    b_i       = b;
    out_ready = ordy;
    @(negedge clk);
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && (q[0].stamp < cyc);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("in_ready_w%0d", wd[k]), {63'd0, ir_w[k]}, {63'd0, exp_ir});
      check_eq($sformatf("out_valid_w%0d", wd[k]), {63'd0, ov_w[k]}, {63'd0, exp_ov});
      if (exp_ov) begin
        ey = ref_y(q[0].op, q[0].a, q[0].b, wd[k]);
        check_eq($sformatf("y_w%0d", wd[k]), ys[k], ey);
        check_eq($sformatf("zero_w%0d", wd[k]), {63'd0, zs_w[k]}, {63'd0, (ey == 64'd0)});
`ifdef LOGIC_UNIT_PARITY_EN
        check_eq($sformatf("parity_w%0d", wd[k]), {63'd0, pr_w[k]}, {63'd0, ^ey});
`endif
      end
    end
    if (exp_ov && q[0].has_e) begin
      check_eq("y_directed_w32", ys[1], q[0].e);
    end
    fire_in  = v && exp_ir;
    fire_out = exp_ov && ordy;
    @(posedge clk);
    cyc++;
    if (fire_out) begin
      void'(q.pop_front());
    end
    if (fire_in) begin
      t.op = op; t.a = a; t.b = b; t.stamp = cyc; t.has_e = has_e; t.e = e;
      q.push_back(t);
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_out_valid_w%0d", tag, wd[k]), {63'd0, ov_w[k]}, 64'd0);
      check_eq($sformatf("%s_y_w%0d", tag, wd[k]), ys[k], 64'd0);
      check_eq($sformatf("%s_zero_w%0d", tag, wd[k]), {63'd0, zs_w[k]}, 64'd0);
      check_eq($sformatf("%s_in_ready_w%0d", tag, wd[k]), {63'd0, ir_w[k]}, 64'd1);
`ifdef LOGIC_UNIT_PARITY_EN
      check_eq($sformatf("%s_parity_w%0d", tag, wd[k]), {63'd0, pr_w[k]}, 64'd0);
`endif
    end
  endtask

  logic [63:0] sweep_e [8];
  logic [63:0] ra;
  logic [63:0] rb;
  logic [2:0]  rop;
  logic        rv;
  int          acc;
  int          idx;
  bit          pend;

  initial begin
    sweep_e = '{64'h0000_0000_00F0_1234, 64'h0000_0000_FFF0_FFFF, 64'h0000_0000_000F_0000,
                64'h0000_0000_0F0F_EDCB, 64'h0000_0000_FF00_EDCB, 64'h0000_0000_FF0F_EDCB,
                64'h0000_0000_00FF_1234, 64'h0000_0000_F0F0_1234};
    in_valid = 1'b0; op_i = 3'd0; a_i = 64'd0; b_i = 64'd0; out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    check_reset_outputs("por");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Op sweep back-to-back at full throughput.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 64'h0000_0000_F0F0_1234, 64'h0000_0000_0FF0_FFFF, 1'b1, 1'b1, sweep_e[i]);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);

    // Zero flag and parity corner values.
    step(1'b1, 3'd0, 64'h0000_0000_FFFF_0000, 64'h0000_0000_0000_FFFF, 1'b1, 1'b1, 64'd0);
    step(1'b1, 3'd3, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b1, 64'd0);
    step(1'b1, 3'd7, 64'h0000_0000_0000_0007, 64'd0, 1'b1, 1'b1, 64'h7);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);

    // Backpressure: five PASS ops, OUT_READY low for the first four cycles.
    idx = 0;
    for (int c = 0; c < 30 && (idx < 5 || q.size() > 0); c++) begin
      ra = 64'h0000_0000_1111_1111 * 64'(idx + 1);
      step(idx < 5, 3'd7, ra, 64'd0, c >= 4, 1'b1, ra);
      if (fire_in) idx++;
      if (c == 2) check_eq("bp_in_ready_dropped", {63'd0, ir_w[1]}, 64'd0);
    end
    check_eq("bp_accepted", 64'(idx), 64'd5);

    // Both stages full, then drain and fill on the same edge.
    step(1'b1, 3'd4, 64'h0000_0000_AAAA_5555, 64'h0000_0000_FFFF_0000, 1'b0, 1'b1, 64'h0000_0000_5555_5555);
    step(1'b1, 3'd5, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1, 64'd0);
    step(1'b1, 3'd1, 64'h0000_0000_1234_0000, 64'h0000_0000_0000_5678, 1'b1, 1'b1, 64'h0000_0000_1234_5678);
    check_eq("sim_in_flight", 64'(q.size()), 64'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);

    // Reset with two results in flight.
    step(1'b1, 3'd1, 64'h0000_0000_0F0F_0F0F, 64'd1, 1'b0, 1'b0, 64'd0);
    step(1'b1, 3'd2, 64'h0000_0000_0F0F_0F0F, 64'd1, 1'b0, 1'b0, 64'd0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);

    // Random valid/ready traffic; VALID and its data are held until accepted.
    acc = 0; pend = 1'b0; rv = 1'b0; rop = 3'd0; ra = 64'd0; rb = 64'd0;
    for (int c = 0; c < 40000 && acc < 10000; c++) begin
      if (!pend) begin
        rv  = ($urandom_range(0, 3) != 0);
        rop = 3'($urandom);
        ra  = {$urandom, $urandom};
        rb  = {$urandom, $urandom};
      end
      step(rv, rop, ra, rb, ($urandom_range(0, 3) != 0), 1'b0, 64'd0);
      if (fire_in) acc++;
      pend = rv && !fire_in;
    end
    check_eq("rand_accepted", 64'(acc), 64'd10000);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
    check_eq("drained_out_valid", {61'd0, ov_w}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
